// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - operation/observation bundle for the load/store add/sub datapath
interface datapath_if #(
   parameter int DATA_W = 64
);
   logic              enable;
   logic [4:0]        a;
   logic [4:0]        b;
   logic [DATA_W-1:0] din;
   logic              load_store;
   logic              op_ula;
   logic              operation_type;
   logic              ula_entry;
   logic [4:0]        w;
   logic [DATA_W-1:0] douta;
   logic [DATA_W-1:0] doutb;

   modport master (
      output enable, a, b, din, load_store, op_ula, operation_type, ula_entry, w,
      input  douta, doutb
   );

   modport slave (
      input  enable, a, b, din, load_store, op_ula, operation_type, ula_entry, w,
      output douta, doutb
   );
endinterface

// File: rtl/datapath.sv
// rtl/datapath.sv - single-cycle register file + add/sub ALU + data RAM; DATAPATH_ZERO_REG_EN hardwires reg[0] to 0
module datapath #(
   parameter int DATA_W = 64,
   parameter int MEM_AW = 5
) (
   input  logic       clk,
   input  logic       rst,
   datapath_if.slave  bus
);
   localparam int NUM_REGS  = 32;
   localparam int MEM_DEPTH = 2 ** MEM_AW;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] mem  [MEM_DEPTH];

   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] op2;
   logic [DATA_W-1:0] res;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd;
   logic              reg_wr_ok;

   assign rd_a = regs[bus.a];
   assign rd_b = regs[bus.b];

   assign bus.douta = rd_a;
   assign bus.doutb = rd_b;

   always_comb begin
      op2 = bus.ula_entry ? rd_a : bus.din;
      res = bus.op_ula ? (rd_b + op2) : (rd_b - op2);
   end

   // Only the low address bits are used, so negative offsets simply wrap around the RAM.
   assign mem_addr = res[MEM_AW-1:0];
   assign mem_rd   = mem[mem_addr];

`ifdef DATAPATH_ZERO_REG_EN
   assign reg_wr_ok = (bus.w != 5'd0);
`else
   assign reg_wr_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= DATA_W'(i);
         end
         for (int j = 0; j < MEM_DEPTH; j++) begin
            mem[j] <= DATA_W'(j);
         end
      end else if (bus.enable) begin
         if (!bus.load_store) begin
            mem[mem_addr] <= rd_a;
         end else if (reg_wr_ok) begin
            regs[bus.w] <= bus.operation_type ? res : mem_rd;
         end
      end
   end
endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed self-checking bench for datapath
module tb_datapath;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   datapath_if #(.DATA_W(64)) bus ();

   datapath #(.DATA_W(64), .MEM_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_op(input logic ls, input logic ot, input logic ou, input logic ue,
                         input logic [4:0] aa, input logic [4:0] bb, input logic [4:0] ww,
                         input logic [63:0] dd);
      bus.load_store     = ls;
      bus.operation_type = ot;
      bus.op_ula         = ou;
      bus.ula_entry      = ue;
      bus.a              = aa;
      bus.b              = bb;
      bus.w              = ww;
      bus.din            = dd;
   endtask

   task automatic exec(input logic ls, input logic ot, input logic ou, input logic ue,
                       input logic [4:0] aa, input logic [4:0] bb, input logic [4:0] ww,
                       input logic [63:0] dd);
      set_op(ls, ot, ou, ue, aa, bb, ww, dd);
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
   endtask

   task automatic read_reg(input logic [4:0] idx, output logic [63:0] val);
      bus.a = idx;
      #1;
      val = bus.douta;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         bus.a = 5'(i);
         bus.b = 5'(31 - i);
         #1;
         checks++;
         if (bus.douta !== 64'(i) || bus.doutb !== 64'(31 - i)) begin
            failures++;
            $display("FAIL reset_read idx=%0d douta=%0d doutb=%0d required %0d %0d",
                     i, bus.douta, bus.doutb, i, 31 - i);
         end
      end
   endtask

   task automatic test_store_load();
      logic [63:0] v;
      exec(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd6, 5'd0, 64'd2);     // mem[8] <= 4
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd13, 5'd2, 64'd3);    // reg[2] <= mem[16]
      read_reg(5'd2, v);
      checks++;
      if (v !== 64'd16) begin
         failures++;
         $display("FAIL load_reg2 got=%0d required=16", v);
      end
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd31, 64'd8);    // reg[31] <= mem[8]
      read_reg(5'd31, v);
      checks++;
      if (v !== 64'd4) begin
         failures++;
         $display("FAIL load_after_store got=%0d required=4", v);
      end
   endtask

   task automatic test_alu_imm();
      logic [63:0] v;
      exec(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 64'd31);    // reg[3] <= 31
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd15, 5'd3, 5'd15, -64'sd85);
      bus.enable = 1'b1;
      #1;
      checks++;
      if (bus.douta !== 64'd15 || bus.doutb !== 64'd31) begin
         failures++;
         $display("FAIL read_before_write douta=%0d doutb=%0d required 15 31", bus.douta, bus.doutb);
      end
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      checks++;
      if (bus.douta !== -64'sd54) begin
         failures++;
         $display("FAIL add_imm got=%0d required=-54", $signed(bus.douta));
      end
      exec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd16, -64'sd42);
      read_reg(5'd16, v);
      checks++;
      if (v !== 64'd42) begin
         failures++;
         $display("FAIL sub_imm got=%0d required=42", $signed(v));
      end
   endtask

   task automatic test_reg_reg();
      logic [63:0] v;
      exec(1'b1, 1'b1, 1'b1, 1'b1, 5'd16, 5'd15, 5'd17, 64'd999);
      read_reg(5'd17, v);
      checks++;
      if (v !== -64'sd12) begin
         failures++;
         $display("FAIL rr_add got=%0d required=-12", $signed(v));
      end
      exec(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd18, 64'd999);
      read_reg(5'd18, v);
      checks++;
      if (v !== -64'sd31) begin
         failures++;
         $display("FAIL rr_sub got=%0d required=-31", $signed(v));
      end
      exec(1'b1, 1'b1, 1'b1, 1'b1, 5'd18, 5'd17, 5'd19, 64'd0);
      read_reg(5'd19, v);
      checks++;
      if (v !== -64'sd43) begin
         failures++;
         $display("FAIL rr_add_neg got=%0d required=-43", $signed(v));
      end
      exec(1'b1, 1'b1, 1'b0, 1'b1, 5'd27, 5'd16, 5'd20, 64'd0);
      read_reg(5'd20, v);
      checks++;
      if (v !== 64'd15) begin
         failures++;
         $display("FAIL rr_sub_pos got=%0d required=15", $signed(v));
      end
   endtask

   task automatic test_enable();
      logic [63:0] v;
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd20, 64'd77);
      bus.enable = 1'b0;
      @(posedge clk);
      #1;
      read_reg(5'd20, v);
      checks++;
      if (v !== 64'd15) begin
         failures++;
         $display("FAIL enable_off_reg got=%0d required=15", $signed(v));
      end
      set_op(1'b0, 1'b0, 1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 64'd9);  // store to mem[9] suppressed
      @(posedge clk);
      #1;
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd21, 64'd9);
      read_reg(5'd21, v);
      checks++;
      if (v !== 64'd9) begin
         failures++;
         $display("FAIL enable_off_mem got=%0d required=9", $signed(v));
      end
   endtask

   task automatic test_boundary();
      logic [63:0] v;
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 5'd22, -64'sd40);  // 16-40=-24 -> addr 8 -> 4
      read_reg(5'd22, v);
      checks++;
      if (v !== 64'd4) begin
         failures++;
         $display("FAIL neg_offset_load got=%0d required=4", $signed(v));
      end
      exec(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd23, 64'h7FFF_FFFF_FFFF_FFFF);
      read_reg(5'd23, v);
      checks++;
      if (v !== 64'h8000_0000_0000_0000) begin
         failures++;
         $display("FAIL add_wrap got=%h required=8000000000000000", v);
      end
      exec(1'b0, 1'b0, 1'b1, 1'b0, 5'd23, 5'd30, 5'd0, 64'd5);    // 35 -> mem[3]
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd24, 64'd3);
      read_reg(5'd24, v);
      checks++;
      if (v !== 64'h8000_0000_0000_0000) begin
         failures++;
         $display("FAIL store_addr_wrap got=%h required=8000000000000000", v);
      end
   endtask

   task automatic test_zero_reg();
      logic [63:0] v;
      logic [63:0] exp;
      exec(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 64'd100);
      read_reg(5'd0, v);
`ifdef DATAPATH_ZERO_REG_EN
      exp = 64'd0;
`else
      exp = 64'd105;
`endif
      checks++;
      if (v !== exp) begin
         failures++;
         $display("FAIL zero_reg_write got=%0d required=%0d", v, exp);
      end
   endtask

   task automatic test_reset_restore();
      logic [63:0] v;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         bus.a = 5'(i);
         bus.b = 5'(i);
         #1;
         checks++;
         if (bus.douta !== 64'(i) || bus.doutb !== 64'(i)) begin
            failures++;
            $display("FAIL reset_restore idx=%0d douta=%0d doutb=%0d required %0d",
                     i, bus.douta, bus.doutb, i);
         end
      end
      exec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd25, 64'd8);
      read_reg(5'd25, v);
      checks++;
      if (v !== 64'd8) begin
         failures++;
         $display("FAIL reset_mem got=%0d required=8", v);
      end
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 5'd26, 5'd0, 5'd26, 64'd500);
      bus.enable = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.enable = 1'b0;
      read_reg(5'd26, v);
      checks++;
      if (v !== 64'd26) begin
         failures++;
         $display("FAIL reset_over_enable got=%0d required=26", v);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.enable = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0);
      @(posedge clk);
      #1;
      test_reset();
      test_store_load();
      test_alu_imm();
      test_reg_reg();
      test_enable();
      test_boundary();
      test_zero_reg();
      test_reset_restore();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
